// File: rtl/audio_pkg.sv
// audio_pkg: shared definitions for the audio denoise path.
//   AUDIO_W  - native audio sample width
//   state_t  - moving_avg_denoise control states
//   sample_t - signed audio sample
package audio_pkg;

  localparam int AUDIO_W = 16;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  typedef logic signed [AUDIO_W-1:0] sample_t;

endpackage : audio_pkg

// File: rtl/sample_ring.sv
// sample_ring: N-entry circular sample history (N = 2**LOG2_TAPS) with a
// single pointer shared by reads and writes.
//   clk, rst  - clock, synchronous active-high reset (resets pointer only)
//   clr_en    - write 0 at ptr and advance (clear sweep)
//   wr_en     - write wr_data at ptr and advance (accepted sample)
//   wr_data   - sample to store
//   rd_old    - combinational read of the entry at ptr (oldest sample)
//   ptr       - current pointer, wraps N-1 -> 0
module sample_ring
  import audio_pkg::*;
#(
  parameter int DATA_W    = AUDIO_W,
  parameter int LOG2_TAPS = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr_en,
  input  logic                 wr_en,
  input  logic [DATA_W-1:0]    wr_data,
  output logic [DATA_W-1:0]    rd_old,
  output logic [LOG2_TAPS-1:0] ptr
);

  localparam int N = 1 << LOG2_TAPS;

  logic [DATA_W-1:0]    r_mem [N];
  logic [LOG2_TAPS-1:0] r_ptr;

  // N is a power of two, so the natural pointer overflow is the wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (clr_en || wr_en) begin
      r_ptr <= r_ptr + LOG2_TAPS'(1);
    end
  end

  // Storage has no reset; the clear sweep zeroes it before any read matters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (clr_en) begin
        r_mem[r_ptr] <= '0;
      end else if (wr_en) begin
        r_mem[r_ptr] <= wr_data;
      end
    end
  end

  assign rd_old = r_mem[r_ptr];
  assign ptr    = r_ptr;

endmodule : sample_ring

// File: rtl/moving_avg_denoise.sv
// moving_avg_denoise: streaming mean of the last 2**LOG2_TAPS accepted
// signed samples, with optional bypass of the output value.
//   CLK        - clock, rising edge
//   RST        - synchronous active-high reset
//   in_valid   - audio_in holds a sample
//   in_ready   - block can accept a sample (high in RUN)
//   audio_in   - signed input sample
//   bypass     - output the accepted sample itself instead of the mean
//   out_valid  - one-cycle pulse, one cycle after each accept
//   audio_out  - filtered or bypassed sample, holds when out_valid=0
//   dbg_state  - current control state (0 = CLEAR, 1 = RUN)
//
// Handshake: a sample transfers on a rising edge where in_valid && in_ready
// are both high. in_ready depends only on registered state, never on
// in_valid. The output side has no ready; out_valid must be consumed.
module moving_avg_denoise
  import audio_pkg::*;
#(
  parameter int DATA_W    = AUDIO_W,
  parameter int LOG2_TAPS = 3
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] audio_in,
  input  logic              bypass,
  output logic              out_valid,
  output logic [DATA_W-1:0] audio_out,
  output logic              dbg_state
);

  // Sum of N samples needs LOG2_TAPS growth bits and can never overflow.
  localparam int SUM_W = DATA_W + LOG2_TAPS;

  state_t                   r_state;
  logic signed [SUM_W-1:0]  r_sum;
  logic                     r_out_valid;
  logic [DATA_W-1:0]        r_audio_out;

  logic                     w_accept;
  logic                     w_clr_en;
  logic [DATA_W-1:0]        w_old;
  logic [LOG2_TAPS-1:0]     w_ptr;
  logic signed [SUM_W-1:0]  w_in_ext;
  logic signed [SUM_W-1:0]  w_old_ext;
  logic signed [SUM_W-1:0]  w_new_sum;
  logic [DATA_W-1:0]        w_avg;

  assign w_accept = in_valid && (r_state == ST_RUN);
  assign w_clr_en = (r_state == ST_CLEAR);

  sample_ring #(
    .DATA_W    (DATA_W),
    .LOG2_TAPS (LOG2_TAPS)
  ) u_ring (
    .clk     (CLK),
    .rst     (RST),
    .clr_en  (w_clr_en),
    .wr_en   (w_accept),
    .wr_data (audio_in),
    .rd_old  (w_old),
    .ptr     (w_ptr)
  );

  assign w_in_ext  = SUM_W'($signed(audio_in));
  assign w_old_ext = SUM_W'($signed(w_old));
  assign w_new_sum = r_sum + w_in_ext - w_old_ext;

  // Dropping the low LOG2_TAPS bits of a two's-complement sum is an
  // arithmetic shift right (floor toward -inf); the mean always fits DATA_W.
  assign w_avg = w_new_sum[SUM_W-1:LOG2_TAPS];

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= ST_CLEAR;
      r_sum       <= '0;
      r_out_valid <= 1'b0;
      r_audio_out <= '0;
    end else begin
      r_out_valid <= w_accept;
      case (r_state)
        ST_CLEAR: begin
          // The ring is writing its last entry this cycle.
          if (&w_ptr) begin
            r_state <= ST_RUN;
            r_sum   <= '0;
          end
        end
        ST_RUN: begin
          if (w_accept) begin
            r_sum       <= w_new_sum;
            r_audio_out <= bypass ? audio_in : w_avg;
          end
        end
        default: r_state <= ST_CLEAR;
      endcase
    end
  end

  assign in_ready  = (r_state == ST_RUN);
  assign out_valid = r_out_valid;
  assign audio_out = r_audio_out;
  assign dbg_state = r_state;

endmodule : moving_avg_denoise

// File: tb/tb_moving_avg_denoise.sv
module tb_moving_avg_denoise;

  localparam int W = 16;

  // ---------------- clock / reset ----------------
  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] audio_in = '0;
  logic         bypass = 1'b0;
  logic         out_valid;
  logic [W-1:0] audio_out;
  logic         dbg_state;

  always #5 CLK = ~CLK;

  moving_avg_denoise #(
    .DATA_W    (W),
    .LOG2_TAPS (3)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .audio_in  (audio_in),
    .bypass    (bypass),
    .out_valid (out_valid),
    .audio_out (audio_out),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int           n_cmp = 0;
  int           n_bad = 0;
  logic         mon_en    = 1'b0;
  logic         exp_ov    = 1'b0;
  logic         exp_rdy   = 1'b0;
  logic         chk_zero  = 1'b0;
  logic         final_chk = 1'b0;

  // ---------------- monitor (all comparisons) ----------------
  always @(negedge CLK) begin
    if (mon_en) begin
      n_cmp++;
      if (out_valid !== exp_ov) begin
        n_bad++;
        $display("FAIL out_valid t=%0t got=%b want=%b", $time, out_valid, exp_ov);
      end
      n_cmp++;
      if (in_ready !== exp_rdy) begin
        n_bad++;
        $display("FAIL in_ready t=%0t got=%b want=%b", $time, in_ready, exp_rdy);
      end
      n_cmp++;
      if (dbg_state !== exp_rdy) begin
        n_bad++;
        $display("FAIL dbg_state t=%0t got=%b want=%b", $time, dbg_state, exp_rdy);
      end
      if (chk_zero) begin
        n_cmp++;
        if (audio_out !== '0) begin
          n_bad++;
          $display("FAIL reset_audio_out t=%0t got=%0d want=0", $time, $signed(audio_out));
        end
      end
      if (out_valid === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_output t=%0t got=%0d want=none", $time, $signed(audio_out));
        end else begin
          logic [W-1:0] e;
          e = exp_q.pop_front();
          if (audio_out !== e) begin
            n_bad++;
            $display("FAIL audio_out t=%0t got=%0d want=%0d", $time, $signed(audio_out), $signed(e));
          end
        end
      end
    end
    if (final_chk) begin
      n_cmp++;
      if (exp_q.size() != 0) begin
        n_bad++;
        $display("FAIL drain got=%0d pending want=0", exp_q.size());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input int v, input logic b, input int e);
    logic [31:0] ev;
    ev = e;
    audio_in = v[W-1:0];
    bypass   = b;
    in_valid = 1'b1;
    exp_q.push_back(ev[W-1:0]);
    @(posedge CLK); #1;
    exp_ov   = 1'b1;
    chk_zero = 1'b0;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    bypass   = 1'b0;
    @(posedge CLK); #1;
    exp_ov = 1'b0;
  endtask

  // One-cycle reset pulse with in_valid held high, then the 8-cycle clear.
  task automatic reset_seq();
    RST      = 1'b1;
    in_valid = 1'b1;
    audio_in = 16'h04D2;
    bypass   = 1'b0;
    @(posedge CLK); #1;
    RST      = 1'b0;
    exp_ov   = 1'b0;
    exp_rdy  = 1'b0;
    chk_zero = 1'b1;
    repeat (8) begin
      @(posedge CLK); #1;
    end
    exp_rdy  = 1'b1;
    in_valid = 1'b0;
  endtask

  function automatic int min8(input int k);
    return (k < 8) ? k : 8;
  endfunction

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(posedge CLK);
    #1;
    exp_rdy  = 1'b0;
    exp_ov   = 1'b0;
    chk_zero = 1'b1;
    mon_en   = 1'b1;

    reset_seq();

    // DC ramp of 1000
    for (int k = 1; k <= 12; k++) send(1000, 1'b0, (k < 8) ? 125 * k : 1000);
    idle();

    // Decay back to an all-zero history
    for (int k = 1; k <= 8; k++) send(0, 1'b0, 1000 - 125 * k);

    // Impulse with pointer wrap: 32767/8 floors to 4095
    send(32767, 1'b0, 4095);
    for (int k = 1; k <= 9; k++) send(0, 1'b0, (k < 8) ? 4095 : 0);
    idle();

    // Negative full scale
    for (int k = 1; k <= 16; k++) send(-32768, 1'b0, (k < 8) ? -4096 * k : -32768);

    // Positive full scale replacing it
    for (int k = 1; k <= 16; k++) begin
      int s;
      s = -262144 + min8(k) * 65535;
      send(32767, 1'b0, s >>> 3);
    end

    // Steady -1
    for (int k = 1; k <= 16; k++) begin
      int s;
      s = 262136 - min8(k) * 32768;
      send(-1, 1'b0, s >>> 3);
    end

    // Zeros over a -1 history: floor keeps -1 until the sum reaches 0
    for (int k = 1; k <= 8; k++) send(0, 1'b0, (k < 8) ? -1 : 0);
    idle();

    // Alternate-cycle accepts
    for (int k = 1; k <= 4; k++) begin
      send(800, 1'b0, 100 * k);
      idle();
    end

    // Bypass then averaged
    send(500, 1'b1, 500);
    send(500, 1'b0, 525);
    idle();

    // Mid-stream reset after 5 samples of 800
    send(800, 1'b0, 625);
    for (int k = 2; k <= 5; k++) send(800, 1'b0, 725);
    reset_seq();
    send(800, 1'b0, 100);
    idle();
    idle();

    final_chk = 1'b1;
    @(negedge CLK); #1;
    final_chk = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_moving_avg_denoise
